// File: rtl/rle_packer_pkg.sv
// Shared widths, field positions and pack/unpack helpers for the run-length packer.
package rle_packer_pkg;

    localparam int VAL_W   = 9;
    localparam int CNT_W   = 8;
    localparam int PAIR_W  = VAL_W + CNT_W;
    localparam int CNT_LSB = 0;
    localparam int CNT_MSB = CNT_LSB + CNT_W - 1;
    localparam int VAL_LSB = CNT_MSB + 1;
    localparam int VAL_MSB = VAL_LSB + VAL_W - 1;
    localparam int DROP_W  = 16;

    typedef logic [PAIR_W-1:0] pair_t;

    function automatic pair_t pack_pair(input logic [VAL_W-1:0] value,
                                        input logic [CNT_W-1:0] count);
        pair_t p;
        p = {PAIR_W{1'b0}};
        p[VAL_MSB:VAL_LSB] = value;
        p[CNT_MSB:CNT_LSB] = count;
        return p;
    endfunction

    function automatic logic [CNT_W-1:0] unpack_count(input pair_t p);
        return p[CNT_MSB:CNT_LSB];
    endfunction

endpackage

// File: rtl/rle_pair_fifo.sv
// Pair FIFO: synchronous write, registered head word, extra-MSB pointers for full/empty.
module rle_pair_fifo
    import rle_packer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  pair_t                  wr_data,
    input  logic                   rd_en,
    output pair_t                  rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    pair_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    pair_t         rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    // Next pointers, occupancy and the head word presented after this edge
    always_comb begin
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d    = wr_ptr_d - rd_ptr_d;
        rd_valid_d = (level_d != {PW{1'b0}});
        // The new head is the slot being written now only when everything older is gone
        if (!rd_valid_d) begin
            rd_data_d = rd_data_q;
        end else if (rd_ptr_d == wr_ptr_q) begin
            rd_data_d = wr_data;
        end else begin
            rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // Storage array, not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Pointer, occupancy and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            level_q    <= {PW{1'b0}};
            rd_data_q  <= {PAIR_W{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign level    = level_q;

endmodule

// File: rtl/rle_packer.sv
// Packs encoder (value,count) runs into a FIFO of 17-bit words, one push per new run.
// Optional RLE_PACK_DROP_CNT_EN adds a saturating drop_cnt output.
module rle_packer
    import rle_packer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [VAL_W-1:0] in_value,
    input  logic        [CNT_W-1:0] in_count,
    output logic       [PAIR_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    ovf,
    output logic [$clog2(DEPTH):0]  level
`ifdef RLE_PACK_DROP_CNT_EN
    ,
    output logic       [DROP_W-1:0] drop_cnt
`endif
);
    localparam int LW = $clog2(DEPTH) + 1;

    pair_t cur_pair_s, prev_q, prev_d;
    logic  new_pair_s, pop_s, full_s, push_s, drop_s;
    logic  ovf_q, ovf_d;

    // Change detection against last cycle's pair, and push/drop arbitration
    always_comb begin
        cur_pair_s = pack_pair(in_value, in_count);
        prev_d     = cur_pair_s;
        new_pair_s = (cur_pair_s != prev_q) && (unpack_count(cur_pair_s) != {CNT_W{1'b0}});
        pop_s      = out_valid & out_ready;
        full_s     = (level == LW'(DEPTH));
        push_s     = new_pair_s & (~full_s | pop_s);
        drop_s     = new_pair_s & full_s & ~pop_s;
        ovf_d      = ovf_q | drop_s;
    end

    // Previous-pair and sticky overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= {PAIR_W{1'b0}};
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf = ovf_q;

`ifdef RLE_PACK_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped pairs
    always_comb begin
        if (drop_s && (drop_cnt_q != {DROP_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= {DROP_W{1'b0}};
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    rle_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push_s),
        .wr_data  (cur_pair_s),
        .rd_en    (pop_s),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .level    (level)
    );

endmodule
